// File: rtl/nextasic_pkg.sv
// Shared monitor-link types: frame width, frame type and receiver state encoding.
package nextasic_pkg;

  localparam int unsigned FRAME_W = 40;

  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    RECOVER
  } mon_rx_state_t;

endpackage

// File: rtl/mon_frame_receiver_if.sv
// Valid/ready frame stream from the monitor-link receiver to its ASIC-side consumer.
interface mon_frame_receiver_if
  import nextasic_pkg::*;
();

  frame_t data;
  logic   valid;
  logic   ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/mon_rx_fifo.sv
// Synchronous frame FIFO with wrap-bit pointers, registered read data and no write-to-read bypass.
module mon_rx_fifo
  import nextasic_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter type         data_t = frame_t
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  data_t wr_data,
  input  logic  pop,
  output data_t rd_data,
  output logic  valid,
  output logic  full,
  output logic  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic        do_push, do_pop;
  data_t       mem [DEPTH];
  data_t       rd_data_q;
  logic        valid_q;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign wr_ptr_d = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr + (AW+1)'(do_pop);

  assign rd_data = rd_data_q;
  assign valid   = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      valid_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_d;
      rd_ptr  <= rd_ptr_d;
      valid_q <= (wr_ptr_d != rd_ptr_d);
    end
  end

  // Storage and read register need no reset; a write landing on the next head is forwarded
  // into the read register so it is visible one cycle later, never in the same cycle.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
    if (do_push && (wr_ptr[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      rd_data_q <= wr_data;
    end else begin
      rd_data_q <= mem[rd_ptr_d[AW-1:0]];
    end
  end

endmodule

// File: rtl/mon_frame_receiver.sv
// Monitor-link inbound deserializer: start/40 data/stop framing into a frame FIFO.
// Optional MON_RX_ERRCNT_EN adds a saturating 8-bit err_count of frame_err/overrun pulses.
module mon_frame_receiver
  import nextasic_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        mon_clk,
  input  logic                        reset,
  input  logic                        to_mon,
  mon_frame_receiver_if.master        out,
  output logic                        frame_err,
  output logic                        overrun,
`ifdef MON_RX_ERRCNT_EN
  output logic [7:0]                  err_count,
`endif
  output logic                        busy
);

  mon_rx_state_t state;
  logic [5:0]    bit_cnt;
  frame_t        shreg;
  frame_t        fifo_rd_data;
  logic          fifo_valid, fifo_full, fifo_empty;
  logic          push, pop_ok;

  assign push      = (state == STOP) && to_mon;
  assign pop_ok    = out.ready && !fifo_empty;
  assign out.data  = fifo_rd_data;
  assign out.valid = fifo_valid;

  always_ff @(posedge mon_clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (!to_mon) begin
            state   <= DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        DATA: begin
          shreg <= {shreg[FRAME_W-2:0], to_mon};
          if (bit_cnt == 6'(FRAME_W - 1)) begin
            state <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        STOP: begin
          if (to_mon) begin
            state   <= IDLE;
            busy    <= 1'b0;
            overrun <= fifo_full && !pop_ok;
          end else begin
            state     <= RECOVER;
            frame_err <= 1'b1;
          end
        end
        RECOVER: begin
          if (to_mon) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MON_RX_ERRCNT_EN
  always_ff @(posedge mon_clk) begin
    if (reset) begin
      err_count <= '0;
    end else if ((frame_err || overrun) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

  mon_rx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (frame_t)
  ) u_fifo (
    .clk     (mon_clk),
    .reset   (reset),
    .push    (push),
    .wr_data (shreg),
    .pop     (out.ready),
    .rd_data (fifo_rd_data),
    .valid   (fifo_valid),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_mon_frame_receiver.sv
// Scoreboard bench for mon_frame_receiver; checks err_count when MON_RX_ERRCNT_EN is defined.
module tb_mon_frame_receiver;
  import nextasic_pkg::*;

  logic mon_clk = 1'b0;
  logic reset;
  logic to_mon;
  logic frame_err, overrun, busy;
`ifdef MON_RX_ERRCNT_EN
  logic [7:0] err_count;
`endif

  mon_frame_receiver_if out_if ();

  mon_frame_receiver #(
    .FIFO_DEPTH (4)
  ) dut (
    .mon_clk   (mon_clk),
    .reset     (reset),
    .to_mon    (to_mon),
    .out       (out_if),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef MON_RX_ERRCNT_EN
    .err_count (err_count),
`endif
    .busy      (busy)
  );

  always #5 mon_clk = ~mon_clk;

  int     total = 0;
  int     bad = 0;
  int     err_seen = 0;
  int     ovr_seen = 0;
  bit     mon_en = 1'b0;
  frame_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented frame must match the scoreboard head; pop on handshake.
  always @(negedge mon_clk) begin
    if (mon_en) begin
      if (frame_err === 1'b1) err_seen++;
      if (overrun === 1'b1) ovr_seen++;
      if (out_if.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h want none", out_if.data);
        end else begin
          check("frame_data", 64'(out_if.data), 64'(exp_q[0]));
          if (out_if.ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge mon_clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    to_mon = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    err_seen = 0;
    ovr_seen = 0;
  endtask

  task automatic send_frame(input frame_t d, input bit stop, input bit rdy_at_stop,
                            input bit chk_lat);
    to_mon = 1'b0;
    tick();
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      to_mon = d[i];
      tick();
    end
    to_mon = stop;
    if (rdy_at_stop) out_if.ready = 1'b1;
    if (chk_lat) check("latency_pre", 64'(out_if.valid), 64'd0);
    tick();
    if (rdy_at_stop) out_if.ready = 1'b0;
    to_mon = 1'b1;
  endtask

  task automatic drain();
    out_if.ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("drained_valid", 64'(out_if.valid), 64'd0);
    out_if.ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    to_mon       = 1'b1;
    out_if.ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(out_if.valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
`ifdef MON_RX_ERRCNT_EN
    check("rst_err_count", 64'(err_count), 64'd0);
`endif
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single good frame, 42-cycle latency.
    do_reset();
    out_if.ready = 1'b1;
    exp_q.push_back(40'hA5_1234_5678);
    send_frame(40'hA5_1234_5678, 1'b1, 1'b0, 1'b1);
    check("latency_valid", 64'(out_if.valid), 64'd1);
    repeat (5) tick();
    check("t1_err", 64'(err_seen), 64'd0);
    check("t1_ovr", 64'(ovr_seen), 64'd0);
    check("t1_consumed", 64'(exp_q.size()), 64'd0);

    // Bad stop bit, line held low, then released.
    do_reset();
    send_frame(40'hA5_1234_5678, 1'b0, 1'b0, 1'b0);
    to_mon = 1'b0;
    repeat (10) tick();
    check("t2_busy_low", 64'(busy), 64'd1);
    check("t2_err_once", 64'(err_seen), 64'd1);
    to_mon = 1'b1;
    tick();
    check("t2_busy_idle", 64'(busy), 64'd0);
    repeat (3) tick();
    check("t2_no_frame", 64'(out_if.valid), 64'd0);
    check("t2_err_still_once", 64'(err_seen), 64'd1);
    out_if.ready = 1'b0;

    // Six back-to-back frames into a depth-4 FIFO with no consumer.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) exp_q.push_back(40'(k));
      send_frame(40'(k), 1'b1, 1'b0, 1'b0);
    end
    repeat (3) tick();
    check("t3_overrun", 64'(ovr_seen), 64'd2);
    check("t3_err", 64'(err_seen), 64'd0);
`ifdef MON_RX_ERRCNT_EN
    check("t3_err_count", 64'(err_count), 64'd2);
`endif
    drain();

    // Full FIFO with a pop in the same cycle as the fifth push.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(40'(k));
      send_frame(40'(k), 1'b1, (k == 5), 1'b0);
    end
    repeat (3) tick();
    check("t4_no_overrun", 64'(ovr_seen), 64'd0);
    check("t4_depth", 64'(exp_q.size()), 64'd4);
    drain();

    // Reset in the middle of a frame, then a clean frame.
    do_reset();
    to_mon = 1'b0;
    tick();
    for (int i = FRAME_W - 1; i >= 20; i--) begin
      to_mon = (i % 3 == 0);
      tick();
    end
    reset  = 1'b1;
    to_mon = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_valid", 64'(out_if.valid), 64'd0);
    repeat (20) tick();
    check("t5_no_err", 64'(err_seen), 64'd0);
    out_if.ready = 1'b1;
    exp_q.push_back(40'hFF_0000_00FF);
    send_frame(40'hFF_0000_00FF, 1'b1, 1'b0, 1'b0);
    repeat (5) tick();
    check("t5_received", 64'(exp_q.size()), 64'd0);
    out_if.ready = 1'b0;

    // Drain three frames with ready toggling every cycle.
    do_reset();
    exp_q.push_back(40'h11_2233_4455);
    send_frame(40'h11_2233_4455, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(40'h66_7788_99AA);
    send_frame(40'h66_7788_99AA, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(40'hBB_CCDD_EEFF);
    send_frame(40'hBB_CCDD_EEFF, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      out_if.ready = ~out_if.ready;
      tick();
    end
    check("t6_drained", 64'(exp_q.size()), 64'd0);
    check("t6_valid_drop", 64'(out_if.valid), 64'd0);
    out_if.ready = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
